// File: rtl/mul_share_arb.sv
// Round-robin share of one pipelined 4x4 multiplier between two requesters.
// Requester-ID tags ride a shadow pipeline; MUL_SHARE_ARB_STATS_EN adds grant counters.
module mul_share_arb #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_a,
    input  logic [3:0]  req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_a,
    input  logic [3:0]  req1_b,
    output logic [3:0]  mul_a,
    output logic [3:0]  mul_b,
    input  logic [7:0]  mul_m,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [7:0]  rsp_m
`ifdef MUL_SHARE_ARB_STATS_EN
   ,output logic [15:0] gnt0_cnt,
    output logic [15:0] gnt1_cnt
`endif
);

    logic         ptr_q, ptr_d;
    logic         hs0, hs1;
    logic [3:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [LAT:0] tag_v_q, tag_v_d, tag_id_q, tag_id_d;
    logic [7:0]   rsp_m_q, rsp_m_d;
    logic         rsp0_q, rsp0_d, rsp1_q, rsp1_d;

    // ptr_q == 0 favours requester 0 on a tie
    always_comb begin
        req0_ready = req0_valid & (~req1_valid | ~ptr_q);
        req1_ready = req1_valid & (~req0_valid | ptr_q);
        hs0        = req0_valid & req0_ready;
        hs1        = req1_valid & req1_ready;

        ptr_d = ptr_q;
        if (hs0)      ptr_d = 1'b1;
        else if (hs1) ptr_d = 1'b0;

        mul_a_d = 4'd0;
        mul_b_d = 4'd0;
        if (hs0) begin
            mul_a_d = req0_a;
            mul_b_d = req0_b;
        end else if (hs1) begin
            mul_a_d = req1_a;
            mul_b_d = req1_b;
        end

        rsp_m_d = rsp_m_q;
        if (tag_v_q[LAT]) rsp_m_d = mul_m;
        rsp0_d = tag_v_q[LAT] & ~tag_id_q[LAT];
        rsp1_d = tag_v_q[LAT] &  tag_id_q[LAT];
    end

    // Bit 0 is the issue stage; bit LAT lines up with the product on mul_m.
    if (LAT == 0) begin : g_tag_nolat
        assign tag_v_d  = hs0 | hs1;
        assign tag_id_d = hs1;
    end else begin : g_tag_lat
        assign tag_v_d  = {tag_v_q[LAT-1:0],  hs0 | hs1};
        assign tag_id_d = {tag_id_q[LAT-1:0], hs1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= 1'b0;
            mul_a_q  <= 4'd0;
            mul_b_q  <= 4'd0;
            tag_v_q  <= '0;
            tag_id_q <= '0;
            rsp_m_q  <= 8'd0;
            rsp0_q   <= 1'b0;
            rsp1_q   <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            tag_v_q  <= tag_v_d;
            tag_id_q <= tag_id_d;
            rsp_m_q  <= rsp_m_d;
            rsp0_q   <= rsp0_d;
            rsp1_q   <= rsp1_d;
        end
    end

    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign rsp_m      = rsp_m_q;
    assign rsp0_valid = rsp0_q;
    assign rsp1_valid = rsp1_q;

`ifdef MUL_SHARE_ARB_STATS_EN
    logic [15:0] gnt0_q, gnt0_d, gnt1_q, gnt1_d;

    // Saturating handshake counters
    always_comb begin
        gnt0_d = gnt0_q;
        gnt1_d = gnt1_q;
        if (hs0 && gnt0_q != 16'hFFFF) gnt0_d = gnt0_q + 16'd1;
        if (hs1 && gnt1_q != 16'hFFFF) gnt1_d = gnt1_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt0_q <= 16'd0;
            gnt1_q <= 16'd0;
        end else begin
            gnt0_q <= gnt0_d;
            gnt1_q <= gnt1_d;
        end
    end

    assign gnt0_cnt = gnt0_q;
    assign gnt1_cnt = gnt1_q;
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb with a LAT=2 multiplier model.
module tb_mul_share_arb;
    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0] mul_a, mul_b;
    logic [7:0] mul_m, rsp_m;
    logic       rsp0_valid, rsp1_valid;
`ifdef MUL_SHARE_ARB_STATS_EN
    logic [15:0] gnt0_cnt, gnt1_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Two-stage multiplier: operands in cycle n, product on mul_m in cycle n+2
    logic [7:0] m_s1, m_s2;
    always @(posedge clk) begin
        m_s1 <= {4'd0, mul_a} * {4'd0, mul_b};
        m_s2 <= m_s1;
    end
    assign mul_m = m_s2;

    mul_share_arb #(.LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_m(rsp_m)
`ifdef MUL_SHARE_ARB_STATS_EN
       ,.gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt)
`endif
    );

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        req0_valid = 1'b0; req0_a = 4'd0; req0_b = 4'd0;
        req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0;
    endtask

    task automatic do_reset;
        idle();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        idle();
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5;
        nxt();
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL reset_ready0 got %b exp 1", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1 got %b exp 0", req1_ready); end
        checks++; if (mul_a !== 4'd0) begin errors++; $display("FAIL reset_mul_a got %0d exp 0", mul_a); end
        checks++; if (rsp_m !== 8'd0) begin errors++; $display("FAIL reset_rsp_m got %0d exp 0", rsp_m); end
        checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errors++; $display("FAIL reset_rsp got %b exp 00", {rsp0_valid, rsp1_valid}); end
        nxt();
        rst = 1'b0;
        idle();
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if ({mul_a, mul_b} !== 8'h00) begin errors++; $display("FAIL post_reset_mul c=%0d got %h exp 00", c, {mul_a, mul_b}); end
            checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errors++; $display("FAIL post_reset_rsp c=%0d got %b exp 00", c, {rsp0_valid, rsp1_valid}); end
            nxt();
        end
    endtask

    task automatic test_single;
        do_reset();
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready got %b exp 10", {req0_ready, req1_ready}); end
        nxt();
        idle();
        #1;
        checks++; if ({mul_a, mul_b} !== {4'd3, 4'd5}) begin errors++; $display("FAIL single_mul got %h exp 35", {mul_a, mul_b}); end
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) #1;
            checks++; if (rsp0_valid !== (c == 4)) begin errors++; $display("FAIL single_rsp0 c=%0d got %b exp %b", c, rsp0_valid, c == 4); end
            checks++; if (rsp1_valid !== 1'b0) begin errors++; $display("FAIL single_rsp1 c=%0d got %b exp 0", c, rsp1_valid); end
            if (c == 4) begin
                checks++; if (rsp_m !== 8'd15) begin errors++; $display("FAIL single_rsp_m got %0d exp 15", rsp_m); end
            end
            nxt();
        end
    endtask

    task automatic test_contention;
        bit e0, e1;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c < 4) begin
                req0_valid = 1'b1; req0_a = 4'd2;  req0_b = 4'd2;
                req1_valid = 1'b1; req1_a = 4'd15; req1_b = 4'd15;
            end else idle();
            #1;
            if (c < 4) begin
                checks++; if ({req0_ready, req1_ready} !== ((c % 2 == 0) ? 2'b10 : 2'b01))
                    begin errors++; $display("FAIL cont_grant c=%0d got %b", c, {req0_ready, req1_ready}); end
            end
            e0 = (c >= 4 && c < 8 && c % 2 == 0);
            e1 = (c >= 4 && c < 8 && c % 2 == 1);
            checks++; if ({rsp0_valid, rsp1_valid} !== {e0, e1}) begin errors++; $display("FAIL cont_rsp c=%0d got %b exp %b", c, {rsp0_valid, rsp1_valid}, {e0, e1}); end
            if (e0 || e1) begin
                checks++; if (rsp_m !== (e0 ? 8'd4 : 8'd225)) begin errors++; $display("FAIL cont_rsp_m c=%0d got %0d exp %0d", c, rsp_m, e0 ? 4 : 225); end
            end
            nxt();
        end
    endtask

    task automatic test_back_to_back;
        int npulse, last_m, k;
        bit e1;
        npulse = 0; last_m = -1;
        do_reset();
        for (int c = 0; c < 262; c++) begin
            if (c < 256) begin
                req1_valid = 1'b1;
                {req1_a, req1_b} = 8'(c);
            end else idle();
            #1;
            if (c < 256) begin
                checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready c=%0d got %b exp 1", c, req1_ready); end
            end
            e1 = (c >= 4 && c < 260);
            checks++; if ({rsp0_valid, rsp1_valid} !== {1'b0, e1}) begin errors++; $display("FAIL b2b_rsp c=%0d got %b exp %b", c, {rsp0_valid, rsp1_valid}, {1'b0, e1}); end
            if (e1) begin
                k = c - 4;
                checks++; if (rsp_m !== 8'((k / 16) * (k % 16))) begin errors++; $display("FAIL b2b_rsp_m k=%0d got %0d exp %0d", k, rsp_m, (k / 16) * (k % 16)); end
            end
            if (rsp1_valid === 1'b1) begin
                npulse++;
                last_m = int'(rsp_m);
            end
            nxt();
        end
        checks++; if (npulse != 256) begin errors++; $display("FAIL b2b_count got %0d exp 256", npulse); end
        checks++; if (last_m != 225) begin errors++; $display("FAIL b2b_last got %0d exp 225", last_m); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd9;
        nxt();
        idle();
        req1_valid = 1'b1; req1_a = 4'd4; req1_b = 4'd6;
        #1;
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL mid_ready1 got %b exp 1", req1_ready); end
        nxt();
        idle();
        rst = 1'b1;
        #1;
        checks++; if ({mul_a, mul_b} !== {4'd4, 4'd6}) begin errors++; $display("FAIL mid_issue got %h exp 46", {mul_a, mul_b}); end
        nxt();
        rst = 1'b0;
        for (int c = 3; c < 16; c++) begin
            if (c == 9) begin
                req0_valid = 1'b1; req0_a = 4'd6; req0_b = 4'd7;
            end else idle();
            #1;
            if (c == 3) begin
                checks++; if ({mul_a, mul_b, rsp_m} !== 16'h0000) begin errors++; $display("FAIL mid_clear got %h exp 0000", {mul_a, mul_b, rsp_m}); end
            end
            if (c == 9) begin
                checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL mid_ready0 got %b exp 1", req0_ready); end
            end
            checks++; if ({rsp0_valid, rsp1_valid} !== {c == 13, 1'b0}) begin errors++; $display("FAIL mid_rsp c=%0d got %b exp %b", c, {rsp0_valid, rsp1_valid}, {c == 13, 1'b0}); end
            if (c == 13) begin
                checks++; if (rsp_m !== 8'd42) begin errors++; $display("FAIL mid_rsp_m got %0d exp 42", rsp_m); end
            end
            nxt();
        end
    endtask

`ifdef MUL_SHARE_ARB_STATS_EN
    task automatic test_stats;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1;
            req1_valid = (c >= 2); req1_a = 4'd2; req1_b = 4'd2;
            nxt();
        end
        idle();
        #1;
        checks++; if (gnt0_cnt !== 16'd5) begin errors++; $display("FAIL stats_gnt0 got %0d exp 5", gnt0_cnt); end
        checks++; if (gnt1_cnt !== 16'd3) begin errors++; $display("FAIL stats_gnt1 got %0d exp 3", gnt1_cnt); end
        do_reset();
        #1;
        checks++; if ({gnt0_cnt, gnt1_cnt} !== 32'd0) begin errors++; $display("FAIL stats_reset got %h exp 0", {gnt0_cnt, gnt1_cnt}); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_reset_mid();
`ifdef MUL_SHARE_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Shares one 4x4 unsigned multiplier (operands a/b, 8-bit product m, fixed pipeline latency) between two requesters.
- Round-robin arbitration, one issue per cycle.
- Each issued operation carries a requester-ID tag down a shadow pipeline matched to the multiplier latency, so every product returns to the requester that issued it.
- Sits between the two requesting units and the multiplier instance.

Parameters:
- LAT, 2: multiplier latency in cycles, from operands on mul_a/mul_b to product valid on mul_m. Legal range 0..8; 0 means a combinational multiplier.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 handshake accepted this cycle
- req0_a  in  4  requester 0 operand a
- req0_b  in  4  requester 0 operand b
- req1_valid  in  1  requester 1 has an operation
- req1_ready  out  1  requester 1 handshake accepted this cycle
- req1_a  in  4  requester 1 operand a
- req1_b  in  4  requester 1 operand b
- mul_a  out  4  operand a to multiplier, registered
- mul_b  out  4  operand b to multiplier, registered
- mul_m  in  8  product from multiplier
- rsp0_valid  out  1  one-cycle pulse: rsp_m belongs to requester 0
- rsp1_valid  out  1  one-cycle pulse: rsp_m belongs to requester 1
- rsp_m  out  8  product, registered

Behaviour:
- Single clock domain. Reset is synchronous and active-high: clk and rst only.
- Reset values:
  - mul_a, mul_b, rsp_m = 0.
  - rsp0_valid, rsp1_valid = 0.
  - Tag pipeline cleared, so no response may emerge from pre-reset operations.
  - RR pointer set so requester 0 wins the first tie.
- reqN_ready is combinational from reqN_valid and the RR pointer, never from the other ready:
  - Exactly one valid: that requester gets ready.
  - Both valid: requester favoured by the pointer gets ready; the other gets ready=0.
  - Neither valid: both ready=0.
  - Never both ready=1 in the same cycle.
- Handshake = reqN_valid & reqN_ready, sampled at the rising edge.
- The RR pointer updates only on a handshake and points to the other requester afterwards.
- Requesters must hold valid/a/b stable until handshake. The block does not check this.
- Issue stage, on the edge closing handshake cycle t:
  - mul_a/mul_b <= granted operands.
  - issue_v <= 1, issue_id <= N.
  - With no handshake: mul_a/mul_b <= 0 and issue_v <= 0.
- Tag pipeline:
  - LAT registered stages after the issue stage.
  - The stage-LAT output aligns with the cycle mul_m carries that issue's product.
  - For LAT = 0 the issue-stage tag aligns directly.
- Response stage, at the next edge:
  - rsp_m <= mul_m when the aligned tag is valid; otherwise rsp_m holds its last value.
  - rspN_valid <= aligned tag valid & (id == N).
- Latency:
  - rspN_valid is high in cycle t+2+LAT for a handshake in cycle t.
  - Fixed and independent of load.
  - Throughput is 1 operation per cycle.
- No response backpressure: the consumer must accept every rsp pulse.
- Ordering: responses return in issue order and are never reordered or dropped.
- rsp0_valid and rsp1_valid are never high together.
- Continuous contention (both valid every cycle) yields a strict alternation 0,1,0,1,... starting from the current pointer.
- rst asserted mid-stream:
  - In-flight tags are discarded.
  - No rsp pulse appears after the reset edge.
  - Outputs return to reset values at that edge.

Optional Feature:
- Macro MUL_SHARE_ARB_STATS_EN.
- When defined:
  - Adds output ports gnt0_cnt[15:0] and gnt1_cnt[15:0], counting handshakes per requester.
  - Counters saturate at 16'hFFFF and reset to 0 on rst.
  - They increment on the same edge as the handshake.
- When undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset check:
  - Stimulus: rst high 2 cycles with req0_valid=1 (a=3, b=5).
  - Response: req ready may assert combinationally, but no rsp pulse and mul_a=0 during and 4 cycles after rst deassert.
  - Then drop valid: no spurious rsp.
- Single op, LAT=2:
  - Stimulus: req0 a=3, b=5 handshakes in cycle t.
  - Response: mul_a=3, mul_b=5 in t+1; rsp0_valid=1 with rsp_m=15 in cycle t+4 only; rsp1_valid stays 0.
- Contention:
  - Stimulus: both valid for 4 cycles, req0 a=2 b=2, req1 a=15 b=15.
  - Response: grants 0,1,0,1; responses 4, 225, 4, 225 on rsp0, rsp1, rsp0, rsp1 in consecutive cycles.
- Back-to-back sweep:
  - Stimulus: req1 streams all 256 {a,b} pairs from 8'h00 to 8'hFF, 1 per cycle.
  - Response: 256 consecutive rsp1_valid pulses, each rsp_m = a*b in order; last one = 225.
- Reset mid-flight:
  - Stimulus: 2 ops issued, rst pulsed 1 cycle after the second handshake.
  - Response: zero rsp pulses afterward; next op gets its response at exactly t+2+LAT.
- Stats (macro defined):
  - Stimulus: 5 req0 and 3 req1 handshakes.
  - Response: gnt0_cnt=5, gnt1_cnt=3; both 0 after rst.
